// File: rtl/seg7_pkg.sv
// Shared constants for active-low 7-segment display logic.
package seg7_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned MIN_DIGITS = 1;
  localparam int unsigned MAX_DIGITS = 8;

  // All segments and the decimal point off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

  // Active-low segment bytes for 0..F, bit 7 (DP) always off.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Saturate a nibble into the decimal range.
  function automatic logic [NIBBLE_W-1:0] bcd_clamp(input logic [NIBBLE_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment byte decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [SEG_W-1:0]    seg_o_c
);

  // Table lookup; DP stays off for every code.
  always_comb begin
    seg_o_c = SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/hex_display_counter.sv
// N-digit hex/BCD up/down counter with prescaled tick, leading-zero
// blanking and blinking, driving active-low 7-segment displays.
module hex_display_counter
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 6,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned TICK_HZ     = 10,
  parameter int unsigned BLINK_TICKS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    mode_bcd,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_val,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [4*N_DIGITS-1:0]   value,
  output logic                    wrap,
  output logic [8*N_DIGITS-1:0]   hex
);

  localparam int unsigned VW  = NIBBLE_W * N_DIGITS;
  localparam int unsigned HW  = SEG_W * N_DIGITS;
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0]   presc_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            phase_q;
  logic [VW-1:0]   value_q;
  logic            wrap_q;
  logic [HW-1:0]   hex_q;

  logic            tick_c;
  logic [VW-1:0]   step_d;
  logic            step_wrap_d;
  logic [VW-1:0]   load_d;
  logic [HW-1:0]   hex_d;
  logic [SEG_W-1:0] seg_c [N_DIGITS];

  assign tick_c = (presc_q == PW'(DIV - 1));

  // Free-running prescaler, independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (tick_c) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Blink phase flips every BLINK_TICKS ticks, regardless of en/blink_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (tick_c) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  // Next count value: per-digit ripple in BCD, plain add/sub in hex.
  always_comb begin
    logic                carry;
    logic [NIBBLE_W-1:0] dig;
    logic [NIBBLE_W-1:0] nxt;
    carry       = 1'b1;
    dig         = '0;
    nxt         = '0;
    step_d      = value_q;
    step_wrap_d = 1'b0;
    if (mode_bcd) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        dig = value_q[NIBBLE_W*i +: NIBBLE_W];
        nxt = dig;
        if (carry) begin
          if (up) begin
            if (dig >= BCD_MAX) begin
              nxt   = '0;
              carry = 1'b1;
            end else begin
              nxt   = dig + NIBBLE_W'(1);
              carry = 1'b0;
            end
          end else begin
            if (dig == '0) begin
              nxt   = BCD_MAX;
              carry = 1'b1;
            end else if (dig > BCD_MAX) begin
              nxt   = BCD_MAX - NIBBLE_W'(1);
              carry = 1'b0;
            end else begin
              nxt   = dig - NIBBLE_W'(1);
              carry = 1'b0;
            end
          end
        end
        step_d[NIBBLE_W*i +: NIBBLE_W] = nxt;
      end
      step_wrap_d = carry;
    end else begin
      step_d      = up ? (value_q + VW'(1)) : (value_q - VW'(1));
      step_wrap_d = up ? (&value_q) : (value_q == '0);
    end
  end

  // Load value, with nibbles clamped to 9 in BCD mode.
  always_comb begin
    load_d = load_val;
    if (mode_bcd) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        load_d[NIBBLE_W*i +: NIBBLE_W] = bcd_clamp(load_val[NIBBLE_W*i +: NIBBLE_W]);
      end
    end
  end

  // Count register: load beats a count step, which beats hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else if (load) begin
      value_q <= load_d;
      wrap_q  <= 1'b0;
    end else if (tick_c && en) begin
      value_q <= step_d;
      wrap_q  <= step_wrap_d;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  for (genvar g = 0; g < int'(N_DIGITS); g++) begin : g_dec
    seg7_decode u_dec (
      .nibble_i (value_q[NIBBLE_W*g +: NIBBLE_W]),
      .seg_o_c  (seg_c[g])
    );
  end

  // Display bytes: leading-zero blanking from the top, then blink override.
  always_comb begin
    logic zero_run;
    zero_run = blank_lz;
    hex_d    = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      if (value_q[NIBBLE_W*i +: NIBBLE_W] != '0) begin
        zero_run = 1'b0;
      end
      hex_d[SEG_W*i +: SEG_W] = (zero_run && (i != 0)) ? SEG_BLANK : seg_c[i];
    end
    if (blink_en && phase_q) begin
      hex_d = {N_DIGITS{SEG_BLANK}};
    end
  end

  // Registered display output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= {N_DIGITS{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;
  assign hex   = hex_q;

endmodule

// File: tb/tb_hex_display_counter.sv
// Directed bench for hex_display_counter with N_DIGITS=2, DIV=4, BLINK_TICKS=2.
module tb_hex_display_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        mode_bcd;
  logic        load;
  logic [7:0]  load_val;
  logic        blank_lz;
  logic        blink_en;
  logic [7:0]  value;
  logic        wrap;
  logic [15:0] hex;

  int n_cmp;
  int n_fail;
  int ecount;

  hex_display_counter #(
    .N_DIGITS    (2),
    .CLK_HZ      (8),
    .TICK_HZ     (2),
    .BLINK_TICKS (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .mode_bcd (mode_bcd),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .value    (value),
    .wrap     (wrap),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; a tick step lands on every edge with ecount%4==0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  typedef struct packed {
    logic        bcd;
    logic        blz;
    logic [7:0]  ld;
    logic [7:0]  ev;
    logic [15:0] eh;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the current cycle is a tick cycle.
  task automatic sync_tick();
    for (int k = 0; k < 8 && (ecount % 4) != 3; k++) step();
  endtask

  // Advance through the next tick edge.
  task automatic run_to_tick();
    step();
    for (int k = 0; k < 8 && (ecount % 4) != 0; k++) step();
  endtask

  // Load on a non-tick edge.
  task automatic do_load(input logic [7:0] v);
    if ((ecount % 4) == 3) step();
    load_val = v;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b1; en = 1'b0; up = 1'b1; mode_bcd = 1'b0; load = 1'b0;
    load_val = 8'h00; blank_lz = 1'b0; blink_en = 1'b0;

    vecs[0]  = '{bcd:1'b0, blz:1'b0, ld:8'h00, ev:8'h00, eh:16'hC0C0};
    vecs[1]  = '{bcd:1'b0, blz:1'b0, ld:8'h3A, ev:8'h3A, eh:16'hB088};
    vecs[2]  = '{bcd:1'b0, blz:1'b0, ld:8'hFE, ev:8'hFE, eh:16'h8E86};
    vecs[3]  = '{bcd:1'b0, blz:1'b1, ld:8'h05, ev:8'h05, eh:16'hFF92};
    vecs[4]  = '{bcd:1'b0, blz:1'b1, ld:8'h00, ev:8'h00, eh:16'hFFC0};
    vecs[5]  = '{bcd:1'b0, blz:1'b1, ld:8'h10, ev:8'h10, eh:16'hF9C0};
    vecs[6]  = '{bcd:1'b1, blz:1'b0, ld:8'hAF, ev:8'h99, eh:16'h9090};
    vecs[7]  = '{bcd:1'b1, blz:1'b1, ld:8'h0C, ev:8'h09, eh:16'hFF90};
    vecs[8]  = '{bcd:1'b0, blz:1'b0, ld:8'h7D, ev:8'h7D, eh:16'hF8A1};
    vecs[9]  = '{bcd:1'b0, blz:1'b0, ld:8'hB4, ev:8'hB4, eh:16'h8399};
    vecs[10] = '{bcd:1'b0, blz:1'b0, ld:8'h62, ev:8'h62, eh:16'h82A4};
    vecs[11] = '{bcd:1'b1, blz:1'b0, ld:8'h81, ev:8'h81, eh:16'h80F9};
    vecs[12] = '{bcd:1'b0, blz:1'b0, ld:8'hCE, ev:8'hCE, eh:16'hC686};
    vecs[13] = '{bcd:1'b0, blz:1'b1, ld:8'h0F, ev:8'h0F, eh:16'hFF8E};

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 32'(hex), 32'hFFFF);
    check("rst_value", 32'(value), 32'h00);
    check("rst_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    step();
    check("rel_hex", 32'(hex), 32'hC0C0);
    repeat (19) step();
    check("idle_value", 32'(value), 32'h00);
    check("idle_wrap", 32'(wrap), 32'h0);

    // Decode/blank/clamp table
    for (int i = 0; i < 14; i++) begin
      mode_bcd = vecs[i].bcd;
      blank_lz = vecs[i].blz;
      do_load(vecs[i].ld);
      check($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].ev));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'h0);
      step();
      check($sformatf("vec%0d_hex", i), 32'(hex), 32'(vecs[i].eh));
    end

    // Hex up wrap FE -> FF -> 00
    mode_bcd = 1'b0; up = 1'b1; blank_lz = 1'b0; en = 1'b0;
    sync_tick();
    step();
    en = 1'b1;
    do_load(8'hFE);
    run_to_tick();
    check("hexup_ff", 32'(value), 32'hFF);
    check("hexup_ff_wrap", 32'(wrap), 32'h0);
    run_to_tick();
    check("hexup_00", 32'(value), 32'h00);
    check("hexup_wrap", 32'(wrap), 32'h1);
    step();
    check("hexup_wrap_clr", 32'(wrap), 32'h0);
    check("hexup_hex", 32'(hex), 32'hC0C0);

    // BCD down 10 -> 09 -> 08, clamped load
    mode_bcd = 1'b1; up = 1'b0;
    do_load(8'h10);
    check("bcd_ld10", 32'(value), 32'h10);
    run_to_tick();
    check("bcd_dn_09", 32'(value), 32'h09);
    check("bcd_dn_09_wrap", 32'(wrap), 32'h0);
    run_to_tick();
    check("bcd_dn_08", 32'(value), 32'h08);
    do_load(8'hAF);
    check("bcd_clamp", 32'(value), 32'h99);

    // BCD wraps both directions
    up = 1'b1;
    run_to_tick();
    check("bcd_up_wrap_val", 32'(value), 32'h00);
    check("bcd_up_wrap", 32'(wrap), 32'h1);
    up = 1'b0;
    run_to_tick();
    check("bcd_dn_wrap_val", 32'(value), 32'h99);
    check("bcd_dn_wrap", 32'(wrap), 32'h1);
    step();
    check("bcd_wrap_clr", 32'(wrap), 32'h0);

    // Mode change keeps value, next step counts in hex
    mode_bcd = 1'b0; up = 1'b1;
    check("mode_keep", 32'(value), 32'h99);
    run_to_tick();
    check("mode_hex_step", 32'(value), 32'h9A);

    // Hex down from 00 wraps to FF
    do_load(8'h00);
    up = 1'b0;
    run_to_tick();
    check("hexdn_ff", 32'(value), 32'hFF);
    check("hexdn_wrap", 32'(wrap), 32'h1);

    // BCD steps on an out-of-range digit
    do_load(8'h0B);
    check("ld_0b_hex", 32'(value), 32'h0B);
    mode_bcd = 1'b1;
    run_to_tick();
    check("bcd_dn_gt9", 32'(value), 32'h08);
    mode_bcd = 1'b0;
    do_load(8'h0B);
    mode_bcd = 1'b1; up = 1'b1;
    run_to_tick();
    check("bcd_up_gt9", 32'(value), 32'h10);

    // Load on a tick cycle wins, no count step
    mode_bcd = 1'b0; up = 1'b1; en = 1'b1;
    sync_tick();
    load_val = 8'h42; load = 1'b1;
    step();
    load = 1'b0;
    check("tickload_val", 32'(value), 32'h42);
    check("tickload_wrap", 32'(wrap), 32'h0);
    en = 1'b0;
    step();
    check("tickload_hold", 32'(value), 32'h42);

    // Blink: 8 clk blank, 8 clk digits
    blink_en = 1'b1;
    step();
    for (int k = 0; k < 24; k++) begin
      logic [15:0] exp_hex;
      step();
      exp_hex = ((((ecount - 1) / 8) % 2) == 1) ? 16'hFFFF : 16'h99A4;
      check($sformatf("blink_%0d", k), 32'(hex), 32'(exp_hex));
    end
    check("blink_value", 32'(value), 32'h42);

    // Reset mid-count, first tick DIV clks after release
    blink_en = 1'b0; en = 1'b1; up = 1'b1;
    run_to_tick();
    check("pre_rst_val", 32'(value), 32'h43);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_value", 32'(value), 32'h00);
    check("mid_rst_hex", 32'(hex), 32'hFFFF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_hex", 32'(hex), 32'hC0C0);
    step();
    step();
    check("post_rst_3clk", 32'(value), 32'h00);
    step();
    check("post_rst_tick", 32'(value), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_counter.md
Name: hex_display_counter

Overview:
- Parametrised N-digit up/down counter driving active-low 7-segment displays (bit 7 = decimal point).
- Generalises the single-nibble combinational digit decode to: full 0-F decode, N digits, BCD/hex counting modes, a prescaled count tick, leading-zero blanking and display blink.
- Sits between board switches/keys and the HEXn outputs in the top level.

Parameters:
- N_DIGITS, 6, number of displayed digits/nibbles (1..8)
- CLK_HZ, 50000000, input clock frequency
- TICK_HZ, 10, count-tick rate; divider DIV = CLK_HZ/TICK_HZ; must be ≥2
- BLINK_TICKS, 5, ticks per blink half-period; must be ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  count enable, sampled on tick cycles
- up  in  1  1 = increment, 0 = decrement
- mode_bcd  in  1  1 = each nibble counts 0-9, 0 = binary hex count
- load  in  1  synchronous load of load_val
- load_val  in  4*N_DIGITS  value to load, nibble 0 = least significant digit
- blank_lz  in  1  blank leading zero digits
- blink_en  in  1  enable display blinking
- value  out  4*N_DIGITS  current count
- wrap  out  1  one-cycle pulse on count wrap-around
- hex  out  8*N_DIGITS  segment bytes, digit i at [8i+7:8i], active-low, bit7 = DP

Behaviour:
- Reset (async, rst_n=0): prescaler=0, value=0, blink phase=0, wrap=0, every hex byte=8'hFF (all off). Release is synchronous to clk.
- Prescaler: counts 0..DIV-1 every clk. tick=1 on the cycle the count equals DIV-1, then the count returns to 0. It runs regardless of en.
- Priority per clk: load > (tick & en) count > hold.
  - load: value <= load_val. In BCD mode, any nibble >9 is clamped to 9. wrap=0.
  - A load on a tick cycle suppresses that count step.
- Hex mode count: value ±1 modulo 16^N_DIGITS.
- BCD mode count: per-digit ripple.
  - Up: digit 9 (or any >9) -> 0 with carry.
  - Down: digit 0 -> 9 with borrow. A down step on a digit >9 yields 8.
- Wrap:
  - Up from all-max (all 9s in BCD, all F in hex) gives 0.
  - Down from 0 gives all-max.
  - wrap=1 for exactly the clk cycle the wrapped value is registered; otherwise 0.
- Mode change does not alter value. It takes effect at the next count step.
- Blink phase: toggles every BLINK_TICKS ticks, counted independently of en. When blink_en=0, the phase counter still runs.
- Display: registered, latency 1 clk from value/control to hex.
  - Decode table: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E. DP is always off (bit7=1).
  - Blanking with blank_lz=1: digit i shows FF if it and all higher digits are 0. Digit 0 is never blanked, so value 0 shows "0".
  - blink_en=1 and phase=1: all bytes FF, overriding everything else. value keeps counting.
- Reset mid-count: all state clears immediately. The first tick after release occurs DIV clks later.

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK = 8'hFF
  - 16-entry segment constant table
  - digit-count limits
- Sub-module seg7_decode: combinational, 4-bit nibble in, 8-bit active-low segment byte out. Instantiated N_DIGITS times via generate.
- Counter, prescaler, blink and blanking logic stay in hex_display_counter.

Test Plan (N_DIGITS=2, CLK_HZ=8, TICK_HZ=2 -> DIV=4, BLINK_TICKS=2):
- Reset, then en=0 for 20 clk -> value=00, wrap=0. hex=FFFF during reset and hex=C0C0 one clk after release (blank_lz=0).
- Hex mode, up, en=1, load_val=8'hFE loaded -> 2 ticks later value=8'h00 with wrap=1 for one clk. hex low byte C0 one clk later.
- BCD mode, down, load_val=8'h10 -> next tick value=8'h09, next tick 8'h08. Load 8'hAF -> value=8'h99.
- BCD up from 8'h99 -> 8'h00 with wrap pulse. Down from 8'h00 -> 8'h99 with wrap pulse.
- blank_lz=1, value=8'h05 -> hex=16'hFF92. value=8'h00 -> hex=16'hFFC0.
- blink_en=1 with value held -> hex alternates between FFFF and the digit pattern every 8 clk. load asserted on a tick cycle -> loaded value wins and no count step occurs.
